// File: rtl/avalon_pattern_writer.sv
// rtl/avalon_pattern_writer.sv - Avalon-MM write master filling a region with a test pattern
module avalon_pattern_writer #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 4096,
    parameter int ADDR_STRIDE = 1,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic              continuous,
    input  logic              abort,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [15:0]       pass_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    logic [1:0]        state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] walk;
    logic [1:0]        mode_r;
    logic [DATA_W-1:0] seed_r;
    logic              cont_r;

    logic              accept;
    logic              last;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DATA_W-1:0] walk_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [15:0]       pass_nxt;

    // walk is kept as a rotating one-hot so no modulo by DATA_W is needed
    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] s,
        input logic [IDX_W-1:0]  i,
        input logic [DATA_W-1:0] w
    );
        logic [DATA_W-1:0] sum;
        sum = s + DATA_W'(i);
        case (m)
            2'd0:    return sum;
            2'd1:    return s;
            2'd2:    return w;
            default: return ~sum;
        endcase
    endfunction

    always_comb begin
        accept   = avm_write & ~avm_waitrequest;
        last     = (idx == LAST_IDX);
        idx_nxt  = last ? '0 : idx + 1'b1;
        walk_nxt = last ? ONE : {walk[DATA_W-2:0], walk[DATA_W-1]};
        addr_nxt = last ? BASE : avm_address + STRIDE;
        pass_nxt = (pass_count == 16'hFFFF) ? pass_count : pass_count + 16'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            idx           <= '0;
            walk          <= ONE;
            mode_r        <= 2'd0;
            seed_r        <= '0;
            cont_r        <= 1'b0;
            avm_address   <= BASE;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            pass_count    <= 16'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    if (start) begin
                        mode_r        <= mode;
                        seed_r        <= seed;
                        cont_r        <= continuous;
                        idx           <= '0;
                        walk          <= ONE;
                        pass_count    <= 16'd0;
                        avm_address   <= BASE;
                        avm_writedata <= pattern(mode, seed, '0, ONE);
                        avm_write     <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // abort is only honoured at an acceptance so a pending word is never dropped
                    if (accept) begin
                        idx           <= idx_nxt;
                        walk          <= walk_nxt;
                        avm_address   <= addr_nxt;
                        avm_writedata <= pattern(mode_r, seed_r, idx_nxt, walk_nxt);
                        if (last) begin
                            pass_count <= pass_nxt;
                        end
                        if (abort) begin
                            avm_write <= 1'b0;
                            aborted   <= 1'b1;
                            state     <= ST_FINISH;
                        end else if (last && !cont_r) begin
                            avm_write <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    done    <= 1'b0;
                    aborted <= 1'b0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    avm_write <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
